// File: rtl/bsg_cache_non_blocking_responder.sv
// Cache-side endpoint of the non-blocking vcache packet interface. Requests run against a
// small word array, and {data, id} responses come back in order through a return FIFO.
// Packet layout, MSB first: {opcode[5:0], id, addr, data, mask}.
`timescale 1ns/1ps
module bsg_cache_non_blocking_responder
  #(parameter int data_width_p   = 32
   ,parameter int addr_width_p   = 28
   ,parameter int id_width_p     = 14
   ,parameter int mem_els_p      = 1024
   ,parameter int ret_fifo_els_p = 4
   ,localparam int pkt_width_lp  = 6+id_width_p+addr_width_p+data_width_p+(data_width_p>>3))
   (input  logic                    clk_i
   ,input  logic                    reset_n_i
   ,input  logic [pkt_width_lp-1:0] cache_pkt_i
   ,input  logic                    v_i
   ,output logic                    ready_o
   ,output logic [data_width_p-1:0] data_o
   ,output logic [id_width_p-1:0]   id_o
   ,output logic                    v_o
   ,input  logic                    yumi_i);

   localparam logic [5:0] LB  = 6'b000000;
   localparam logic [5:0] LH  = 6'b000001;
   localparam logic [5:0] LW  = 6'b000010;
   localparam logic [5:0] LBU = 6'b000100;
   localparam logic [5:0] LHU = 6'b000101;
   localparam logic [5:0] SM  = 6'b001100;

   localparam int lg_mem_lp     = $clog2(mem_els_p);
   localparam int mask_width_lp = data_width_p >> 3;
   localparam int cnt_width_lp  = $clog2(ret_fifo_els_p+1);
   localparam int ptr_width_lp  = $clog2(ret_fifo_els_p);

   localparam logic [0:0] INIT  = 1'b0;
   localparam logic [0:0] READY = 1'b1;

   logic [5:0]               pkt_opcode;
   logic [id_width_p-1:0]    pkt_id;
   logic [addr_width_p-1:0]  pkt_addr;
   logic [data_width_p-1:0]  pkt_data;
   logic [mask_width_lp-1:0] pkt_mask;
   assign {pkt_opcode, pkt_id, pkt_addr, pkt_data, pkt_mask} = cache_pkt_i;

   // upper address bits alias onto the array
   logic unused_addr;
   assign unused_addr = ^pkt_addr;

   logic [lg_mem_lp-1:0] word_idx;
   assign word_idx = pkt_addr[2 +: lg_mem_lp];

   logic [0:0]           state_r;
   logic [lg_mem_lp-1:0] init_cnt_r;
   logic                 accept;
   assign accept = v_i & ready_o;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r    <= INIT;
         init_cnt_r <= '0;
      end
      else if (state_r == INIT) begin
         init_cnt_r <= init_cnt_r + 1'b1;
         if (init_cnt_r == lg_mem_lp'(mem_els_p-1))
            state_r <= READY;
      end
   end

   // Backing array is never reset; INIT sweeps zeros through it instead.
   logic [data_width_p-1:0] mem_r [mem_els_p];
   logic [data_width_p-1:0] rd_data_r;

   always_ff @(posedge clk_i) begin
      if (state_r == INIT)
         mem_r[init_cnt_r] <= '0;
      else if (accept && (pkt_opcode == SM)) begin
         for (int b = 0; b < mask_width_lp; b++)
            if (pkt_mask[b])
               mem_r[word_idx][8*b +: 8] <= pkt_data[8*b +: 8];
      end
      if (accept)
         rd_data_r <= mem_r[word_idx];
   end

   logic                  s1_v_r;
   logic [id_width_p-1:0] s1_id_r;
   logic [5:0]            s1_op_r;
   logic [1:0]            s1_sel_r;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s1_v_r   <= 1'b0;
         s1_id_r  <= '0;
         s1_op_r  <= '0;
         s1_sel_r <= '0;
      end
      else begin
         s1_v_r <= accept;
         if (accept) begin
            s1_id_r  <= pkt_id;
            s1_op_r  <= pkt_opcode;
            s1_sel_r <= pkt_addr[1:0];
         end
      end
   end

   logic [7:0]              s1_byte;
   logic [15:0]             s1_half;
   logic [data_width_p-1:0] s1_data;

   always_comb begin
      s1_byte = rd_data_r[{s1_sel_r, 3'b000} +: 8];
      s1_half = s1_sel_r[1] ? rd_data_r[31:16] : rd_data_r[15:0];
      case (s1_op_r)
         LW:      s1_data = rd_data_r;
         LH:      s1_data = {{(data_width_p-16){s1_half[15]}}, s1_half};
         LHU:     s1_data = {{(data_width_p-16){1'b0}}, s1_half};
         LB:      s1_data = {{(data_width_p-8){s1_byte[7]}}, s1_byte};
         LBU:     s1_data = {{(data_width_p-8){1'b0}}, s1_byte};
         default: s1_data = '0;
      endcase
   end

   logic [data_width_p-1:0] fifo_data_r [ret_fifo_els_p];
   logic [id_width_p-1:0]   fifo_id_r   [ret_fifo_els_p];
   logic [ptr_width_lp-1:0] wptr_r, rptr_r;
   logic [cnt_width_lp-1:0] count_r;
   logic                    enq, deq;

   assign enq = s1_v_r;
   assign deq = yumi_i & v_o;

   function automatic logic [ptr_width_lp-1:0] ptr_next(input logic [ptr_width_lp-1:0] p);
      return (p == ptr_width_lp'(ret_fifo_els_p-1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (enq) begin
         fifo_data_r[wptr_r] <= s1_data;
         fifo_id_r[wptr_r]   <= s1_id_r;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end
      else begin
         if (enq) wptr_r <= ptr_next(wptr_r);
         if (deq) rptr_r <= ptr_next(rptr_r);
         if (enq && !deq)
            count_r <= count_r + 1'b1;
         else if (!enq && deq)
            count_r <= count_r - 1'b1;
      end
   end

   // Credits count the stage-1 slot too, so an enqueue never meets a full FIFO.
   logic [cnt_width_lp:0] credits_used;
   assign credits_used = {1'b0, count_r} + (cnt_width_lp+1)'(s1_v_r);
   assign ready_o      = (state_r == READY) && (credits_used < (cnt_width_lp+1)'(ret_fifo_els_p));

   assign v_o    = (count_r != '0);
   assign data_o = fifo_data_r[rptr_r];
   assign id_o   = fifo_id_r[rptr_r];

   yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
   v_known_in_ready: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                      (state_r == READY) |-> !$isunknown(v_i));

endmodule

// File: tb/tb_bsg_cache_non_blocking_responder.sv
// Randomised and directed bench for the responder: a behavioural word-array model and an
// expected-response queue predict every {data, id} the DUT returns.
`timescale 1ns/1ps
module tb_bsg_cache_non_blocking_responder;

   localparam int MEM   = 16;
   localparam int FIFO  = 4;
   localparam int ID_W  = 14;
   localparam int ADR_W = 28;
   localparam int PKT_W = 6 + ID_W + ADR_W + 32 + 4;

   localparam logic [5:0] OP_LB     = 6'b000000;
   localparam logic [5:0] OP_LH     = 6'b000001;
   localparam logic [5:0] OP_LW     = 6'b000010;
   localparam logic [5:0] OP_LBU    = 6'b000100;
   localparam logic [5:0] OP_LHU    = 6'b000101;
   localparam logic [5:0] OP_SW     = 6'b001010;
   localparam logic [5:0] OP_SM     = 6'b001100;
   localparam logic [5:0] OP_TAGST  = 6'b010000;
   localparam logic [5:0] OP_TAGFL  = 6'b010001;
   localparam logic [5:0] OP_TAGLA  = 6'b010011;
   localparam logic [5:0] OP_AFL    = 6'b011000;
   localparam logic [5:0] OP_AFLINV = 6'b011001;
   localparam logic [5:0] OP_AINV   = 6'b011010;

   logic             clk = 1'b0;
   logic             reset_n_i = 1'b0;
   logic [PKT_W-1:0] cache_pkt_i = '0;
   logic             v_i = 1'b0;
   logic             ready_o;
   logic [31:0]      data_o;
   logic [ID_W-1:0]  id_o;
   logic             v_o;
   logic             yumi_i = 1'b0;

   bsg_cache_non_blocking_responder #(
      .data_width_p(32), .addr_width_p(ADR_W), .id_width_p(ID_W),
      .mem_els_p(MEM), .ret_fifo_els_p(FIFO)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n_i), .cache_pkt_i(cache_pkt_i), .v_i(v_i),
      .ready_o(ready_o), .data_o(data_o), .id_o(id_o), .v_o(v_o), .yumi_i(yumi_i)
   );

   // Free-running clock
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]     data;
      logic [ID_W-1:0] id;
      int              acc;
   } exp_t;

   exp_t            expQ[$];
   logic [31:0]     refMem [MEM];
   int              checks = 0;
   int              errors = 0;
   int              cycle = 0;
   bit              yumiOn = 1'b0;
   int              yumiPct = 100;
   bit              lastAccepted;
   logic [31:0]     lastData;
   logic [ID_W-1:0] lastId;
   int              lastLatency;
   logic [5:0]      curOp;
   logic [ID_W-1:0] curId;
   logic [ADR_W-1:0] curAddr;
   logic [31:0]     curData;
   logic [3:0]      curMask;

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Model of one accepted request: compute its response and apply any store
   task automatic modelAccept();
      logic [31:0] w, m, resp;
      logic [7:0]  b;
      logic [15:0] h;
      int          idx;
      exp_t        e;
      idx  = int'(curAddr[5:2]);
      w    = refMem[idx];
      b    = 8'(w >> (8 * curAddr[1:0]));
      h    = 16'(w >> (16 * curAddr[1]));
      resp = 32'h0;
      case (curOp)
         OP_LW:  resp = w;
         OP_LB:  resp = 32'($signed(b));
         OP_LBU: resp = 32'(b);
         OP_LH:  resp = 32'($signed(h));
         OP_LHU: resp = 32'(h);
         OP_SM: begin
            m = 32'h0;
            for (int k = 0; k < 4; k++)
               if (curMask[k]) m = m | (32'hFF << (8 * k));
            refMem[idx] = (w & ~m) | (curData & m);
         end
         default: resp = 32'h0;
      endcase
      e.data = resp;
      e.id   = curId;
      e.acc  = cycle;
      expQ.push_back(e);
   endtask

   // One clock: observe handshakes mid-cycle, then advance and pick next yumi
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (v_o && yumi_i) begin
         if (expQ.size() == 0)
            checkOutput("spurious_resp", 64'(v_o & yumi_i), 64'h0);
         else begin
            e = expQ.pop_front();
            checkOutput("resp_data", data_o, e.data);
            checkOutput("resp_id", id_o, e.id);
            lastLatency = cycle - e.acc;
            checkOutput("resp_latency_min", 64'(lastLatency >= 2), 64'h1);
            lastData = data_o;
            lastId   = id_o;
         end
      end
      lastAccepted = v_i && ready_o;
      if (lastAccepted) modelAccept();
      cycle++;
      @(posedge clk);
      #1;
      yumi_i = v_o && yumiOn && ($urandom_range(0, 99) < yumiPct);
   endtask

   task automatic drivePkt(input logic [5:0] op, input logic [ID_W-1:0] id,
                           input logic [ADR_W-1:0] addr, input logic [31:0] data,
                           input logic [3:0] mask);
      curOp = op; curId = id; curAddr = addr; curData = data; curMask = mask;
      cache_pkt_i = {op, id, addr, data, mask};
   endtask

   // Present one request and hold it until accepted
   task automatic applyStimulus(input logic [5:0] op, input logic [ID_W-1:0] id,
                                input logic [ADR_W-1:0] addr, input logic [31:0] data,
                                input logic [3:0] mask);
      int n = 0;
      drivePkt(op, id, addr, data, mask);
      v_i = 1'b1;
      do begin
         tick();
         n++;
      end while (!lastAccepted && n < 200);
      if (!lastAccepted) checkOutput("accept_timeout", 64'(lastAccepted), 64'h1);
      v_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (expQ.size() > 0 && n < 200) begin
         tick();
         n++;
      end
      if (expQ.size() != 0) checkOutput("drain_timeout", 64'(expQ.size()), 64'h0);
   endtask

   task automatic issueAndCheck(input string tag, input logic [5:0] op,
                                input logic [ID_W-1:0] id, input logic [ADR_W-1:0] addr,
                                input logic [31:0] data, input logic [3:0] mask,
                                input logic [31:0] expData);
      applyStimulus(op, id, addr, data, mask);
      drain();
      checkOutput(tag, lastData, expData);
      checkOutput({tag, "_id"}, lastId, id);
   endtask

   // Hold reset, release it, and measure the INIT sweep
   task automatic doReset();
      int n = 0;
      reset_n_i = 1'b0;
      v_i = 1'b0;
      yumi_i = 1'b0;
      expQ.delete();
      for (int i = 0; i < MEM; i++) refMem[i] = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_ready", 64'(ready_o), 64'h0);
      checkOutput("reset_v", 64'(v_o), 64'h0);
      reset_n_i = 1'b1;
      while (n < 100) begin
         @(negedge clk);
         if (ready_o) break;
         n++;
      end
      checkOutput("init_cycles", 64'(n), 64'(MEM));
      @(posedge clk);
      #1;
   endtask

   logic [5:0] opList [13] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SM, OP_SM, OP_TAGST,
                               OP_TAGFL, OP_TAGLA, OP_AFL, OP_AFLINV, OP_SW};

   initial begin
      int nextId;
      int staleSeen;
      doReset();
      yumiOn = 1'b1; yumiPct = 100;

      issueAndCheck("first_lw", OP_LW, 14'h1, 28'h0, 32'h0, 4'h0, 32'h0);
      checkOutput("min_latency", 64'(lastLatency), 64'h2);
      for (int a = 0; a < MEM; a++) applyStimulus(OP_LW, ID_W'(a), ADR_W'(4 * a), 32'h0, 4'h0);
      drain();

      issueAndCheck("sm_full", OP_SM, 14'h20, 28'h8, 32'h80FF7F01, 4'hF, 32'h0);
      issueAndCheck("lw_8", OP_LW, 14'h21, 28'h8, 32'h0, 4'h0, 32'h80FF7F01);
      issueAndCheck("lb_b", OP_LB, 14'h22, 28'hB, 32'h0, 4'h0, 32'hFFFFFF80);
      issueAndCheck("lbu_b", OP_LBU, 14'h23, 28'hB, 32'h0, 4'h0, 32'h00000080);
      issueAndCheck("lh_a", OP_LH, 14'h24, 28'hA, 32'h0, 4'h0, 32'hFFFF80FF);
      issueAndCheck("lhu_8", OP_LHU, 14'h25, 28'h8, 32'h0, 4'h0, 32'h00007F01);

      issueAndCheck("preload", OP_SM, 14'h30, 28'h10, 32'hAAAAAAAA, 4'hF, 32'h0);
      issueAndCheck("sm_masked", OP_SM, 14'h31, 28'h10, 32'h11223344, 4'b0101, 32'h0);
      issueAndCheck("lw_masked", OP_LW, 14'h32, 28'h10, 32'h0, 4'h0, 32'hAA22AA44);

      issueAndCheck("tagst", OP_TAGST, 14'h3A5, 28'h14, 32'hDEADBEEF, 4'hF, 32'h0);
      issueAndCheck("alias_sm", OP_SM, 14'h40, 28'h40, 32'h5EED1234, 4'hF, 32'h0);
      issueAndCheck("alias_lw", OP_LW, 14'h41, 28'h0, 32'h0, 4'h0, 32'h5EED1234);

      // Back-pressure: yumi held low while six loads compete for credits
      yumiOn = 1'b0;
      nextId = 1;
      for (int c = 0; c < 10 && nextId <= 6; c++) begin
         drivePkt(OP_LW, ID_W'(nextId), ADR_W'(4 * nextId), 32'h0, 4'h0);
         v_i = 1'b1;
         tick();
         if (lastAccepted) nextId++;
      end
      v_i = 1'b0;
      checkOutput("bp_accepted", 64'(nextId - 1), 64'h4);
      checkOutput("bp_ready_low", 64'(ready_o), 64'h0);
      checkOutput("bp_v_high", 64'(v_o), 64'h1);
      yumi_i = v_o;
      checkOutput("bp_ready_same_cycle", 64'(ready_o), 64'h0);
      tick();
      checkOutput("bp_ready_after_yumi", 64'(ready_o), 64'h1);
      yumiOn = 1'b1; yumiPct = 100;
      drain();

      // Random traffic with random back-pressure
      yumiPct = 70;
      for (int c = 0; c < 400; c++) begin
         drivePkt(opList[$urandom_range(0, 12)], ID_W'($urandom), ADR_W'($urandom),
                  32'($urandom), 4'($urandom));
         v_i = ($urandom_range(0, 3) != 0);
         tick();
      end
      v_i = 1'b0;
      yumiPct = 100;
      drain();

      // Reset with loads in flight
      issueAndCheck("pre_rst_sm", OP_SM, 14'h50, 28'h8, 32'hCAFEF00D, 4'hF, 32'h0);
      yumiOn = 1'b0;
      for (int k = 0; k < 3; k++) applyStimulus(OP_LW, ID_W'(14'h60 + k), 28'h8, 32'h0, 4'h0);
      checkOutput("pre_rst_v", 64'(v_o), 64'h1);
      reset_n_i = 1'b0;
      yumi_i = 1'b0;
      #1;
      checkOutput("rst_v_immediate", 64'(v_o), 64'h0);
      checkOutput("rst_ready_immediate", 64'(ready_o), 64'h0);
      doReset();
      yumiOn = 1'b1; yumiPct = 100;
      staleSeen = 0;
      for (int c = 0; c < 8; c++) begin
         if (v_o) staleSeen++;
         tick();
      end
      checkOutput("no_stale_resp", 64'(staleSeen), 64'h0);
      issueAndCheck("post_rst_lw", OP_LW, 14'h70, 28'h8, 32'h0, 4'h0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/bsg_cache_non_blocking_responder.md
Name: bsg_cache_non_blocking_responder

Overview:
- Cache-side endpoint of the non-blocking vcache packet interface.
- Accepts bsg_cache_non_blocking_pkt_s requests (valid/ready) and executes them against a small word-addressed backing array.
- Returns {data, id} responses in order (valid/yumi).
- Stands in for bsg_cache_non_blocking when testing and bringing up manycore link-to-cache adapters and tiles: synthesizable, deterministic latency, no tags.

Parameters:
- data_width_p, 32, word width; must be 32.
- addr_width_p, 28, cache byte-address width.
- id_width_p, 14, request id width; the id is opaque and echoed unchanged.
- mem_els_p, 1024, backing-array words; power of two, >=2.
- ret_fifo_els_p, 4, return FIFO depth; >=2.
- pkt_width_lp, derived, `bsg_cache_non_blocking_pkt_width(id_width_p,addr_width_p,data_width_p).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; asynchronous assert, active-low.
- cache_pkt_i  in  pkt_width_lp  request packet: opcode, id, addr, data, mask.
- v_i  in  1  request valid.
- ready_o  out  1  request ready; transfer when v_i & ready_o.
- data_o  out  data_width_p  response data.
- id_o  out  id_width_p  response id, equal to the request id.
- v_o  out  1  response valid.
- yumi_i  in  1  response consumed; asserted only when v_o=1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (reset_n_i). The flops are asynchronously cleared. Backing array is not reset; it is cleared by the INIT state.
- Reset values: state=INIT, init counter=0, stage-1 valid=0, FIFO empty, v_o=0, ready_o=0.
- State INIT:
  - Writes 0 to array word init_cnt each cycle, then increments init_cnt.
  - After word mem_els_p-1 is written, next state is READY. INIT lasts exactly mem_els_p cycles.
  - ready_o=0 throughout INIT.
- State READY: absorbing state; only reset leaves it.
  - ready_o = (fifo_count + stage1_v) < ret_fifo_els_p.
  - Both terms are sampled in the current cycle; a yumi_i in the same cycle does not raise ready_o in that cycle.
- Word index: addr[2 +: lg(mem_els_p)]. Upper address bits are ignored, so addresses alias modulo mem_els_p*4.
- Request accepted in cycle t:
  - SM: writes bytes where mask[b]=1 (byte b = data[8b+:8]) at the end of t. Response data = 0.
  - LW: reads the whole word.
  - LH / LHU: selects the half-word by addr[1]; sign-extends / zero-extends.
  - LB / LBU: selects the byte by addr[1:0]; sign-extends / zero-extends.
  - TAGST, TAGLA, TAGFL, AFL, AFLINV, AINV: no array effect. Response data = 0.
  - Any other opcode: no array effect. Response data = 0.
  - Cycle t: array read (synchronous). Cycle t+1: stage-1 register holds {id, opcode, sel}; extension is applied and the entry is enqueued at the end of t+1. v_o is asserted in cycle t+2 at the earliest.
  - Minimum request-to-response latency is 2 cycles.
- Ordering: responses return strictly in acceptance order, one per request, stores and tag ops included.
- Read-after-write: a load accepted in any cycle after a store to the same word returns the merged store data. The store write completes at the end of its own accept cycle.
- Throughput: one request per cycle while ready_o=1 and yumi_i keeps up. One response per cycle.
- FIFO:
  - Enqueue and dequeue in the same cycle are allowed; the count is unchanged.
  - The credit rule guarantees a stage-1 enqueue never finds the FIFO full.
  - data_o / id_o are stable while v_o=1 and yumi_i=0.
- Reset mid-operation: all in-flight requests and queued responses are dropped, and INIT runs again. Array writes from the cycle in which reset asserts are discarded.
- Assertions (nonsynth): yumi_i without v_o; X on v_i after INIT.

Test Plan:
- Init: release reset, mem_els_p=16 -> ready_o=0 for exactly 16 cycles then 1. LW at word addresses 0..15 all return 0.
- Store/load extension:
  - SM addr=0x8, data=0x80FF7F01, mask=4'b1111 -> resp data 0.
  - Then from addr=0x8: LW -> 0x80FF7F01; LB addr=0xB -> 0xFFFFFF80; LBU addr=0xB -> 0x00000080; LH addr=0xA -> 0xFFFF80FF; LHU addr=0x8 -> 0x00007F01.
- Masked store: preload 0xAAAAAAAA, then SM data=0x11223344 mask=4'b0101 -> LW returns 0xAA22AA44.
- Back-pressure: ret_fifo_els_p=4, yumi_i=0, 6 back-to-back LW -> exactly 4 accepted, then ready_o=0. Releasing yumi_i for 1 cycle -> ready_o=1 one cycle later. Ids return in issue order 1,2,3,4.
- Tag ops and aliasing: TAGST id=0x3A5 -> data 0, id 0x3A5. SM at addr 0x40 with mem_els_p=16 -> LW at addr 0x0 returns the stored value.
- Reset mid-stream: 3 loads in flight, reset_n_i pulsed low -> v_o=0 immediately, INIT reruns, no stale responses appear.
